// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch program counter and its return-address stack.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_TARGET = 2'b01,
    PC_ALU    = 2'b10,
    PC_TRAP   = 2'b11
  } pcsrc_e;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with a next-free pointer and an occupancy count.
module pc_ras #(
  parameter int RAS_DEPTH = 4,
  parameter int XLEN      = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] top,
  output logic            valid
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   top_idx;
  logic [CW-1:0]   count;
  logic            empty;
  logic            full;
  logic            wr_en;
  logic [PW-1:0]   wr_idx;

  assign top_idx = ptr - 1'b1;
  assign empty   = (count == '0);
  assign full    = (count == CW'(RAS_DEPTH));

  // A push+pop pair on an empty stack degenerates to a plain push.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = ptr;
    if (push && (!pop || empty)) begin
      wr_en  = 1'b1;
      wr_idx = ptr;
    end else if (push && pop) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && (!pop || empty)) begin
      ptr <= ptr + 1'b1;
      if (!full) count <= count + 1'b1;
    end else if (pop && !push && !empty) begin
      ptr   <= top_idx;
      count <= count - 1'b1;
    end
  end

  assign valid = !empty;
  assign top   = empty ? '0 : mem[top_idx];

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch program counter: next-PC selection, misaligned-redirect trapping, fetch handshake and RAS.
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic [1:0]      PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  input  logic [XLEN-1:0] ALUResult,
  input  logic [XLEN-1:0] TrapVector,
  input  logic            Stall,
  input  logic            FetchReady,
  output logic            FetchValid,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic            MisalignTrap,
  output logic [XLEN-1:0] MisalignAddr,
  input  logic            CallPush,
  input  logic            RetPop,
  output logic [XLEN-1:0] RasTop,
  output logic            RasValid
);

  pcsrc_e          src;
  logic [XLEN-1:0] target;
  logic            redirect;
  logic            misalign;
  logic            hold;
  logic [XLEN-1:0] pc_next;
  logic            trap_next;

  assign src     = pcsrc_e'(PCSrc);
  assign PCPlus4 = PC + XLEN'(PC_STEP);

  always_comb begin
    target = '0;
    case (src)
      PC_TARGET: target = PCTarget;
      PC_ALU:    target = ALUResult & ~XLEN'(1);
      PC_TRAP:   target = TrapVector;
      default:   target = '0;
    endcase
  end

  // Trap vectors are trusted, so only branch/jal and jalr targets are alignment-checked.
  assign redirect = (src != PC_SEQ);
  assign misalign = redirect && (src != PC_TRAP) && (target[1:0] != 2'b00);
  assign hold     = Stall || (FetchValid && !FetchReady);

  always_comb begin
    pc_next   = PC;
    trap_next = 1'b0;
    if (!FetchValid) begin
      pc_next = PC;
    end else if (misalign) begin
      pc_next   = TrapVector;
      trap_next = 1'b1;
    end else if (redirect) begin
      pc_next = target;
    end else if (!hold) begin
      pc_next = PCPlus4;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      PC           <= RESET_VECTOR;
      FetchValid   <= 1'b0;
      MisalignTrap <= 1'b0;
      MisalignAddr <= '0;
    end else begin
      PC           <= pc_next;
      FetchValid   <= 1'b1;
      MisalignTrap <= trap_next;
      if (trap_next) MisalignAddr <= target;
    end
  end

  pc_ras #(
    .RAS_DEPTH (RAS_DEPTH),
    .XLEN      (XLEN)
  ) u_ras (
    .clk   (CLK),
    .rst_n (Reset),
    .push  (CallPush && !Stall),
    .pop   (RetPop && !Stall),
    .data  (PCPlus4),
    .top   (RasTop),
    .valid (RasValid)
  );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a reference model feeding an expectation queue.
module tb_pc_fetch_unit;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [1:0]  PCSrc;
  logic [31:0] PCTarget, ALUResult, TrapVector;
  logic        Stall, FetchReady, CallPush, RetPop;
  logic        FetchValid, MisalignTrap, RasValid;
  logic [31:0] PC, PCPlus4, MisalignAddr, RasTop;

  pc_fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .RAS_DEPTH(DEPTH)) dut (
    .CLK(CLK), .Reset(Reset), .PCSrc(PCSrc), .PCTarget(PCTarget), .ALUResult(ALUResult),
    .TrapVector(TrapVector), .Stall(Stall), .FetchReady(FetchReady), .FetchValid(FetchValid),
    .PC(PC), .PCPlus4(PCPlus4), .MisalignTrap(MisalignTrap), .MisalignAddr(MisalignAddr),
    .CallPush(CallPush), .RetPop(RetPop), .RasTop(RasTop), .RasValid(RasValid)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        fv;
    logic        trap;
    logic [31:0] addr;
    logic [31:0] rtop;
    logic        rvalid;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;

  logic [31:0] m_pc = 32'h0;
  logic        m_fv = 1'b0;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_ras[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_fv = 1'b0;
    m_addr = 32'h0;
    m_ras.delete();
  endtask

  task automatic step(input string tag, input logic [1:0] src, input logic [31:0] tgt,
                      input logic [31:0] alu, input logic [31:0] tv, input logic st,
                      input logic rdy, input logic psh, input logic pp);
    exp_t        e;
    logic [31:0] t;
    logic [31:0] npc;
    logic        ntrap;
    PCSrc = src; PCTarget = tgt; ALUResult = alu; TrapVector = tv;
    Stall = st; FetchReady = rdy; CallPush = psh; RetPop = pp;
    npc = m_pc;
    ntrap = 1'b0;
    t = (src == 2'b01) ? tgt : (src == 2'b10) ? {alu[31:1], 1'b0} : tv;
    if (!m_fv) npc = m_pc;
    else if (src != 2'b00 && src != 2'b11 && t[1:0] != 2'b00) begin
      npc = tv; ntrap = 1'b1; m_addr = t;
    end else if (src != 2'b00) npc = t;
    else if (!st && rdy) npc = m_pc + 32'd4;
    if (!st) begin
      if (psh && pp && m_ras.size() > 0) m_ras[m_ras.size()-1] = m_pc + 32'd4;
      else if (psh) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end else if (pp && m_ras.size() > 0) void'(m_ras.pop_back());
    end
    m_pc = npc;
    m_fv = 1'b1;
    e.tag = tag; e.pc = npc; e.fv = 1'b1; e.trap = ntrap; e.addr = m_addr;
    e.rvalid = (m_ras.size() != 0);
    e.rtop = e.rvalid ? m_ras[m_ras.size()-1] : 32'h0;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".pc"}, PC, e.pc);
    chk({e.tag, ".pc4"}, PCPlus4, e.pc + 32'd4);
    chk({e.tag, ".fv"}, {31'd0, FetchValid}, {31'd0, e.fv});
    chk({e.tag, ".trap"}, {31'd0, MisalignTrap}, {31'd0, e.trap});
    chk({e.tag, ".maddr"}, MisalignAddr, e.addr);
    chk({e.tag, ".rtop"}, RasTop, e.rtop);
    chk({e.tag, ".rvalid"}, {31'd0, RasValid}, {31'd0, e.rvalid});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".pc"}, PC, 32'h0);
    chk({tag, ".fv"}, {31'd0, FetchValid}, 32'd0);
    chk({tag, ".trap"}, {31'd0, MisalignTrap}, 32'd0);
    chk({tag, ".maddr"}, MisalignAddr, 32'h0);
    chk({tag, ".rvalid"}, {31'd0, RasValid}, 32'd0);
    chk({tag, ".rtop"}, RasTop, 32'h0);
  endtask

  initial begin
    Reset = 1'b0; PCSrc = 2'b00; PCTarget = '0; ALUResult = '0; TrapVector = '0;
    Stall = 1'b0; FetchReady = 1'b1; CallPush = 1'b0; RetPop = 1'b0;
    #11;
    chk_reset("por");
    Reset = 1'b1;
    step("rel", 2'b00, 0, 0, 0, 0, 1, 0, 0);
    chk("rel_fv", {31'd0, FetchValid}, 32'd1);
    chk("rel_pc", PC, 32'h0);

    step("go100", 2'b01, 32'h100, 0, 0, 0, 1, 0, 0);
    step("seq1", 2'b00, 0, 0, 0, 0, 1, 0, 0);
    step("seq2", 2'b00, 0, 0, 0, 0, 1, 0, 0);
    step("seq3", 2'b00, 0, 0, 0, 0, 1, 0, 0);
    chk("seq3_pc", PC, 32'h10C);
    step("bp", 2'b00, 0, 0, 0, 0, 0, 0, 0);
    chk("bp_pc", PC, 32'h10C);
    step("stall_br", 2'b01, 32'h200, 0, 0, 1, 1, 0, 0);
    chk("stall_br_pc", PC, 32'h200);
    step("jalr", 2'b10, 0, 32'h301, 0, 0, 1, 0, 0);
    chk("jalr_pc", PC, 32'h300);
    step("stall", 2'b00, 0, 0, 0, 1, 1, 0, 0);
    step("mis", 2'b01, 32'h202, 0, 32'h80, 0, 1, 0, 0);
    chk("mis_pc", PC, 32'h80);
    chk("mis_trap", {31'd0, MisalignTrap}, 32'd1);
    chk("mis_addr", MisalignAddr, 32'h202);
    step("mis_after", 2'b00, 0, 0, 32'h80, 0, 1, 0, 0);
    chk("mis_after_trap", {31'd0, MisalignTrap}, 32'd0);
    step("misj", 2'b10, 0, 32'h403, 32'h90, 0, 0, 0, 0);
    step("tv_trust", 2'b11, 0, 0, 32'h82, 0, 1, 0, 0);
    chk("tv_trust_pc", PC, 32'h82);

    step("ras_go0", 2'b01, 32'h0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step("push", 2'b00, 0, 0, 0, 0, 1, 1, 0);
    chk("push5_top", RasTop, 32'h14);
    chk("pop1_top", RasTop, 32'h14);
    step("pop1", 2'b00, 0, 0, 0, 0, 1, 0, 1);
    chk("pop2_top", RasTop, 32'h10);
    step("pop2", 2'b00, 0, 0, 0, 0, 1, 0, 1);
    chk("pop3_top", RasTop, 32'hC);
    step("pop3", 2'b00, 0, 0, 0, 0, 1, 0, 1);
    chk("pop4_top", RasTop, 32'h8);
    step("pop4", 2'b00, 0, 0, 0, 0, 1, 0, 1);
    chk("pop4_valid", {31'd0, RasValid}, 32'd0);
    step("pop_empty", 2'b00, 0, 0, 0, 0, 1, 0, 1);
    chk("pop_empty_valid", {31'd0, RasValid}, 32'd0);
    step("pushA", 2'b00, 0, 0, 0, 0, 1, 1, 0);
    step("pushB", 2'b00, 0, 0, 0, 0, 1, 1, 0);
    step("pushpop", 2'b00, 0, 0, 0, 0, 1, 1, 1);
    step("stall_push", 2'b00, 0, 0, 0, 1, 1, 1, 0);
    step("popX", 2'b00, 0, 0, 0, 0, 1, 0, 1);
    chk("popX_valid", {31'd0, RasValid}, 32'd1);
    step("popY", 2'b00, 0, 0, 0, 0, 1, 0, 1);
    chk("popY_valid", {31'd0, RasValid}, 32'd0);
    step("pp_empty", 2'b00, 0, 0, 0, 0, 1, 1, 1);

    step("go_top", 2'b01, 32'hFFFF_FFFC, 0, 0, 0, 1, 0, 0);
    step("wrap", 2'b00, 0, 0, 0, 0, 1, 0, 0);
    chk("wrap_pc", PC, 32'h0);

    step("pre_rst", 2'b00, 0, 0, 0, 0, 1, 1, 0);
    #2;
    Reset = 1'b0;
    #1;
    chk_reset("midrst");
    model_reset();
    #3;
    Reset = 1'b1;
    step("rel2", 2'b01, 32'h500, 0, 0, 0, 1, 0, 0);
    step("after_rel2", 2'b00, 0, 0, 0, 0, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
